countdown_timer_ctrl: RTL and testbench

Controller for the board's two-digit seven-segment countdown timer. It debounces the two push buttons, loads a preset from the 3-bit switch bank, and runs the seconds prescaler. It also sequences the BCD countdown through an IDLE/RUN/PAUSE/DONE state machine and drives both digit displays. It sits directly under the board top, between the raw button/switch pins and the seg outputs.

---
 rtl/countdown_timer_ctrl_if.sv | 32 +++
 rtl/countdown_timer_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_ctrl_if.sv
// countdown_timer_ctrl_if
//   Groups the pin-side signals of the two-digit countdown timer controller.
//   slave  : controller view (buttons/switches in, digits/segments/status out)
//   master : board-top / bench view (drives buttons/switches, observes outputs)
//   btn1     start/pause button, active-low
//   btn0     clear button, active-low
//   sw20     preset select, preset = (sw20+1)*10 s
//   dig_tens BCD tens digit,  dig_ones BCD ones digit
//   seg1     tens display {g,f,e,d,c,b,a} active-low, seg0 ones display
//   running  high in RUN, done high in DONE, tick one-cycle step pulse in RUN
interface countdown_timer_ctrl_if;
  logic       btn1;
  logic       btn0;
  logic [2:0] sw20;
  logic [3:0] dig_tens;
  logic [3:0] dig_ones;
  logic [6:0] seg1;
  logic [6:0] seg0;
  logic       running;
  logic       done;
  logic       tick;

  modport slave (
    input  btn1, btn0, sw20,
    output dig_tens, dig_ones, seg1, seg0, running, done, tick
  );

  modport master (
    output btn1, btn0, sw20,
    input  dig_tens, dig_ones, seg1, seg0, running, done, tick
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl
//   Two-digit BCD countdown timer controller: synchronizes and debounces the
//   start (btn1) and clear (btn0) buttons, loads a preset from sw20, runs the
//   seconds prescaler and sequences IDLE/RUN/PAUSE/DONE, driving both digits
//   and their seven-segment patterns.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   io   countdown_timer_ctrl_if.slave (btn1, btn0, sw20 in;
//        dig_tens, dig_ones, seg1, seg0, running, done, tick out)
// Parameters:
//   TICK_DIV    clk cycles per countdown step (>= 2)
//   DEB_CYCLES  stable synchronized samples needed to accept a level change (>= 1)
// Build option:
//   BLINK_DONE_EN  when defined, the displays blink in DONE (prescaler keeps
//                  running, each wrap toggles a blank flag).
module countdown_timer_ctrl #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input logic                   clk,
  input logic                   rst,
  countdown_timer_ctrl_if.slave io
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pre, pre_n;
  logic [3:0]      tens, ones, tens_n, ones_n, dec_t, dec_o;
  logic [6:0]      seg1_q, seg0_q;
  logic            tick_c, blank;

  // index 1 = btn1 (start), index 0 = btn0 (clear); level 1 = released
  logic [1:0]      sync1, sync2, deb, ev;
  logic [DW-1:0]   cnt [2];
  logic            start_ev, clr_ev;

`ifdef BLINK_DONE_EN
  logic            blink, blink_n;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // The press event is registered together with the debounced level change,
  // so it is high in the cycle after the DEB_CYCLES-th differing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      ev    <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {io.btn1, io.btn0};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DMAX) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
            ev[i]  <= deb[i];  // only released->pressed produces an event
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign start_ev = ev[1];
  assign clr_ev   = ev[0];

  always_comb begin
    state_n = state;
    pre_n   = pre;
    tens_n  = tens;
    ones_n  = ones;
    tick_c  = (state == RUN) && (pre == PMAX);

    if (ones == 4'd0) begin
      dec_o = 4'd9;
      dec_t = tens - 4'd1;
    end else begin
      dec_o = ones - 4'd1;
      dec_t = tens;
    end

    case (state)
      IDLE:  if (!clr_ev && start_ev) state_n = RUN;
      RUN: begin
        if (clr_ev)                                        state_n = IDLE;
        else if (tick_c && dec_t == 4'd0 && dec_o == 4'd0) state_n = DONE;
        else if (start_ev)                                 state_n = PAUSE;
      end
      PAUSE: begin
        if (clr_ev)        state_n = IDLE;
        else if (start_ev) state_n = RUN;
      end
      DONE:  if (clr_ev || start_ev) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state == RUN) pre_n = tick_c ? '0 : pre + 1'b1;
`ifdef BLINK_DONE_EN
    else if (state == DONE) pre_n = (pre == PMAX) ? '0 : pre + 1'b1;
`endif
    if (state == IDLE && state_n == RUN) pre_n = '0;

    // Loading on the transition edge lets the preset override a same-cycle decrement.
    if (state_n == IDLE) begin
      tens_n = {1'b0, io.sw20} + 4'd1;
      ones_n = 4'd0;
    end else if (tick_c) begin
      tens_n = dec_t;
      ones_n = dec_o;
    end

`ifdef BLINK_DONE_EN
    blink_n = blink;
    if (state_n != DONE)                      blink_n = 1'b0;
    else if (state == DONE && pre == PMAX)    blink_n = ~blink;
    blank = blink_n;
`else
    blank = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pre    <= '0;
      tens   <= '0;
      ones   <= '0;
      seg1_q <= 7'b1000000;
      seg0_q <= 7'b1000000;
`ifdef BLINK_DONE_EN
      blink  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      pre    <= pre_n;
      tens   <= tens_n;
      ones   <= ones_n;
      seg1_q <= blank ? '1 : seg7(tens_n);
      seg0_q <= blank ? '1 : seg7(ones_n);
`ifdef BLINK_DONE_EN
      blink  <= blink_n;
`endif
    end
  end

  assign io.dig_tens = tens;
  assign io.dig_ones = ones;
  assign io.seg1     = seg1_q;
  assign io.seg0     = seg0_q;
  assign io.running  = (state == RUN);
  assign io.done     = (state == DONE);
  assign io.tick     = tick_c;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl
//   Directed bench for countdown_timer_ctrl with TICK_DIV=10, DEB_CYCLES=4.
//   A vector table drives the main start/tick/pause/clear/done flow; short
//   hand-written sequences cover glitches, bouncing, simultaneous events and
//   reset mid-debounce. Inputs change and outputs are sampled on negedges.
//   Timing model: a pin change before edge 1 becomes a press event after
//   edge 6 and the state changes on edge 7.
module tb_countdown_timer_ctrl;
  localparam int unsigned TD = 10;
  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  countdown_timer_ctrl_if bus ();

  countdown_timer_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  typedef struct {
    logic        b1, b0;
    logic [2:0]  sw;
    int unsigned n;
    logic [3:0]  t, o;
    logic        r, d, tk;
  } vec_t;

  vec_t vecs [24];

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] t, input logic [3:0] o,
                         input logic r, input logic d, input logic tk);
    chk({nm, ".tens"},    {4'b0, bus.dig_tens}, {4'b0, t});
    chk({nm, ".ones"},    {4'b0, bus.dig_ones}, {4'b0, o});
    chk({nm, ".seg1"},    {1'b0, bus.seg1},     {1'b0, segtab[t]});
    chk({nm, ".seg0"},    {1'b0, bus.seg0},     {1'b0, segtab[o]});
    chk({nm, ".running"}, {7'b0, bus.running},  {7'b0, r});
    chk({nm, ".done"},    {7'b0, bus.done},     {7'b0, d});
    chk({nm, ".tick"},    {7'b0, bus.tick},     {7'b0, tk});
  endtask

  // Press btn1 and wait for the state change (7 edges from the drive).
  task automatic start_press();
    bus.btn1 = 1'b0; cyc(4);
    bus.btn1 = 1'b1; cyc(3);
  endtask

  initial begin
    // b1 b0 sw  n    tens ones run done tick  (edge count from the v0 edge)
    vecs[0]  = '{1'b1, 1'b1, 3'd2, 1,  4'd3, 4'd0, 1'b0, 1'b0, 1'b0}; // preset 30
    vecs[1]  = '{1'b0, 1'b1, 3'd2, 6,  4'd3, 4'd0, 1'b0, 1'b0, 1'b0}; // 6: event only
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 1,  4'd3, 4'd0, 1'b1, 1'b0, 1'b0}; // 7: RUN
    vecs[3]  = '{1'b0, 1'b1, 3'd2, 3,  4'd3, 4'd0, 1'b1, 1'b0, 1'b0}; // 10
    vecs[4]  = '{1'b1, 1'b1, 3'd2, 6,  4'd3, 4'd0, 1'b1, 1'b0, 1'b1}; // 16: tick
    vecs[5]  = '{1'b1, 1'b1, 3'd2, 1,  4'd2, 4'd9, 1'b1, 1'b0, 1'b0}; // 17
    vecs[6]  = '{1'b1, 1'b1, 3'd2, 10, 4'd2, 4'd8, 1'b1, 1'b0, 1'b0}; // 27
    vecs[7]  = '{1'b1, 1'b1, 3'd0, 10, 4'd2, 4'd7, 1'b1, 1'b0, 1'b0}; // 37: sw ignored
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 4,  4'd2, 4'd7, 1'b1, 1'b0, 1'b0}; // 41
    vecs[9]  = '{1'b1, 1'b1, 3'd0, 3,  4'd2, 4'd7, 1'b0, 1'b0, 1'b0}; // 44: PAUSE, held 7
    vecs[10] = '{1'b1, 1'b1, 3'd0, 50, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0}; // 94 frozen
    vecs[11] = '{1'b0, 1'b1, 3'd0, 4,  4'd2, 4'd7, 1'b0, 1'b0, 1'b0}; // 98
    vecs[12] = '{1'b1, 1'b1, 3'd0, 3,  4'd2, 4'd7, 1'b1, 1'b0, 1'b0}; // 101 resume
    vecs[13] = '{1'b1, 1'b1, 3'd0, 2,  4'd2, 4'd7, 1'b1, 1'b0, 1'b1}; // 103 tick
    vecs[14] = '{1'b1, 1'b1, 3'd0, 1,  4'd2, 4'd6, 1'b1, 1'b0, 1'b0}; // 104 = 101+10-7
    vecs[15] = '{1'b1, 1'b0, 3'd0, 4,  4'd2, 4'd6, 1'b1, 1'b0, 1'b0}; // 108
    vecs[16] = '{1'b1, 1'b1, 3'd0, 3,  4'd1, 4'd0, 1'b0, 1'b0, 1'b0}; // 111 IDLE, 10
    vecs[17] = '{1'b0, 1'b1, 3'd0, 4,  4'd1, 4'd0, 1'b0, 1'b0, 1'b0}; // 115
    vecs[18] = '{1'b1, 1'b1, 3'd0, 3,  4'd1, 4'd0, 1'b1, 1'b0, 1'b0}; // 118 RUN
    vecs[19] = '{1'b1, 1'b1, 3'd0, 99, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1}; // 217
    vecs[20] = '{1'b1, 1'b1, 3'd0, 1,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0}; // 218 DONE
    vecs[21] = '{1'b1, 1'b1, 3'd0, 30, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0}; // steady 00
    vecs[22] = '{1'b0, 1'b1, 3'd0, 4,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0}; // 252
    vecs[23] = '{1'b1, 1'b1, 3'd0, 3,  4'd1, 4'd0, 1'b0, 1'b0, 1'b0}; // 255 IDLE

    rst = 1'b1;
    bus.btn1 = 1'b1;
    bus.btn0 = 1'b1;
    bus.sw20 = 3'd2;
    cyc(3);
    chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      bus.btn1 = vecs[i].b1;
      bus.btn0 = vecs[i].b0;
      bus.sw20 = vecs[i].sw;
      cyc(vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].o, vecs[i].r, vecs[i].d, vecs[i].tk);
    end

    // 3-cycle glitch stays below the debounce threshold
    bus.btn1 = 1'b0; cyc(3);
    bus.btn1 = 1'b1; cyc(15);
    chk("glitch.running", {7'b0, bus.running}, 8'd0);
    chk("glitch.tens", {4'b0, bus.dig_tens}, 8'd1);

    // tick and start event in the same RUN cycle: decrement, then PAUSE
    bus.sw20 = 3'd2; cyc(1);
    start_press();                                   // E
    chk("ts.run", {7'b0, bus.running}, 8'd1);
    cyc(3);                                          // E+3
    bus.btn1 = 1'b0; cyc(4);
    bus.btn1 = 1'b1; cyc(2);                         // E+9: event and tick together
    chk_all("ts.pre", 4'd3, 4'd0, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk_all("ts.pause", 4'd2, 4'd9, 1'b0, 1'b0, 1'b0);
    cyc(20);
    chk_all("ts.frozen", 4'd2, 4'd9, 1'b0, 1'b0, 1'b0);
    bus.btn0 = 1'b0; cyc(4);
    bus.btn0 = 1'b1; cyc(3);
    chk_all("ts.clear", 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);

    // clear and start on the same cycle in RUN: clear wins (preset reloads)
    start_press();                                   // E
    cyc(12);
    chk_all("both.before", 4'd2, 4'd9, 1'b1, 1'b0, 1'b0);
    bus.btn0 = 1'b0; bus.btn1 = 1'b0; cyc(4);
    bus.btn0 = 1'b1; bus.btn1 = 1'b1; cyc(3);        // E+19
    chk_all("both.after", 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(5);
    chk("both.stay", {7'b0, bus.running}, 8'd0);

    // bouncing clear: no event while bouncing, exactly one after settling
    start_press();
    chk("bounce.run", {7'b0, bus.running}, 8'd1);
    for (int k = 0; k < 5; k++) begin
      bus.btn0 = 1'b0; cyc(2);
      bus.btn0 = 1'b1; cyc(2);
    end
    chk("bounce.during", {7'b0, bus.running}, 8'd1);
    bus.btn0 = 1'b0; cyc(6);
    chk("bounce.edge6", {7'b0, bus.running}, 8'd1);
    cyc(1);
    chk("bounce.idle", {7'b0, bus.running}, 8'd0);
    chk("bounce.tens", {4'b0, bus.dig_tens}, 8'd3);
    bus.btn0 = 1'b1; cyc(10);
    bus.btn1 = 1'b0; cyc(4);
    bus.btn1 = 1'b1; cyc(3);
    chk("bounce.restart", {7'b0, bus.running}, 8'd1);

    // reset mid-count and mid-debounce of both buttons
    cyc(13);
    bus.btn0 = 1'b0; bus.btn1 = 1'b0; cyc(3);
    rst = 1'b1; cyc(1);
    chk_all("rstmid", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; bus.btn0 = 1'b1; bus.btn1 = 1'b1; cyc(1);
    chk_all("rstmid.rel", 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(10);
    chk("rstmid.noevent", {7'b0, bus.running}, 8'd0);
    bus.btn1 = 1'b0; cyc(4);
    bus.btn1 = 1'b1; cyc(2);
    chk("rstmid.lat6", {7'b0, bus.running}, 8'd0);
    cyc(1);
    chk("rstmid.lat7", {7'b0, bus.running}, 8'd1);
    cyc(9);
    chk_all("rstmid.tick", 4'd3, 4'd0, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk_all("rstmid.dec", 4'd2, 4'd9, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
